// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the instruction fetch stage.
//   RESET_PC  first fetch address after reset
//   INSN_W    instruction / address width
//   NOP       all-zero instruction word, used as the idle output value
//   fetch_state_e  fetch control states
package mips_pkg;
  localparam int          INSN_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8002_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: single-entry {insn, pc} skid buffer for the fetch stage.
//   clock, reset      clock / async active-high reset
//   load              capture in_insn/in_pc, entry becomes full
//   drain             entry is taken by the consumer, becomes empty
//   clear             flush the entry (wins over load and drain)
//   full              entry holds valid data
//   out_insn, out_pc  buffered pair
module fetch_hold_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_insn,
  input  logic [DATA_W-1:0] in_pc,
  output logic              full,
  output logic [DATA_W-1:0] out_insn,
  output logic [DATA_W-1:0] out_pc
);
  logic              full_q, full_d;
  logic [DATA_W-1:0] insn_q, insn_d, pc_q, pc_d;

  always_comb begin
    full_d = full_q;
    insn_d = insn_q;
    pc_d   = pc_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      insn_d = in_insn;
      pc_d   = in_pc;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      insn_q <= '0;
      pc_q   <= '0;
    end else begin
      full_q <= full_d;
      insn_q <= insn_d;
      pc_q   <= pc_d;
    end
  end

  assign full     = full_q;
  assign out_insn = insn_q;
  assign out_pc   = pc_q;
endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage. Owns the PC, issues one read at a time to
// instruction memory, buffers one word while decode stalls and handles
// redirects, squashing a read that is already in flight.
//   clock, reset                  clock / async active-high reset
//   mem_req, mem_addr             read request; address held until mem_ack
//   mem_ack, mem_rdata            one-cycle response with the word
//   stall                         decode cannot take insn this cycle
//   redirect, redirect_pc         one-cycle stream change (low 2 bits dropped)
//   insn, pc, insn_valid          output pair to decode
module fetch
  import mips_pkg::*;
#(
  parameter int                DATA_W   = INSN_W,
  parameter logic [DATA_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] insn,
  output logic [DATA_W-1:0] pc,
  output logic              insn_valid
);
  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] insn_q, insn_d, pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic              insn_valid_q, insn_valid_d;
  logic              squash_q, squash_d;

  logic              hb_load, hb_drain, hb_clear, hb_full;
  logic [DATA_W-1:0] hb_insn, hb_pc;
  logic              consumed, out_free, req_open;

  fetch_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clock    (clock),
    .reset    (reset),
    .load     (hb_load),
    .drain    (hb_drain),
    .clear    (hb_clear),
    .in_insn  (mem_rdata),
    .in_pc    (fetch_pc_q),
    .full     (hb_full),
    .out_insn (hb_insn),
    .out_pc   (hb_pc)
  );

  assign consumed = insn_valid_q && !stall;
  assign out_free = !insn_valid_q || consumed;
  // request stays on the bus until its ack, whatever happens to fetch_pc
  assign req_open = (state_q == REQ) && !mem_ack;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    squash_d     = squash_q;
    insn_d       = insn_q;
    pc_d         = pc_q;
    insn_valid_d = consumed ? 1'b0 : insn_valid_q;
    hb_load      = 1'b0;
    hb_drain     = 1'b0;
    hb_clear     = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (mem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;          // stale data from before a redirect
          end else if (!redirect) begin
            fetch_pc_d = fetch_pc_q + DATA_W'(4);
            if (out_free) begin
              insn_d       = mem_rdata;
              pc_d         = fetch_pc_q;
              insn_valid_d = 1'b1;
            end else begin
              hb_load = 1'b1;
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          hb_drain     = 1'b1;
          insn_d       = hb_insn;
          pc_d         = hb_pc;
          insn_valid_d = 1'b1;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      fetch_pc_d   = redirect_pc & ~DATA_W'(3);
      insn_valid_d = 1'b0;
      hb_clear     = 1'b1;
      hb_load      = 1'b0;
      hb_drain     = 1'b0;
      state_d      = REQ;
      squash_d     = req_open;        // a still-open read must be thrown away
    end

    mem_req_d  = (state_d == REQ);
    mem_addr_d = req_open ? mem_addr_q : fetch_pc_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      mem_addr_q   <= RESET_PC;
      mem_req_q    <= 1'b0;
      squash_q     <= 1'b0;
      insn_q       <= NOP;
      pc_q         <= '0;
      insn_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      squash_q     <= squash_d;
      insn_q       <= insn_d;
      pc_q         <= pc_d;
      insn_valid_q <= insn_valid_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign insn       = insn_q;
  assign pc         = pc_q;
  assign insn_valid = insn_valid_q;

  logic unused_ok;
  assign unused_ok = hb_full;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: self-checking bench for fetch. A memory responder with variable
// latency returns memf(addr); the reference model is the expected
// instruction stream seen by decode (next pc, +4 per consumed word, reset by
// redirects) plus the request-hold protocol rule.
module tb_fetch;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr, mem_rdata = '0, redirect_pc = '0;
  logic [31:0] insn, pc;
  logic        mem_req, mem_ack = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic        insn_valid;

  fetch dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .insn(insn), .pc(pc),
    .insn_valid(insn_valid)
  );

  always #5 clock = ~clock;

  int          errs = 0, checks = 0;
  logic [31:0] exp_pc = RESET_PC;
  int          lat = 0, wait_cnt = 0, consumed_n = 0;
  bit          rnd_lat = 0, prev_pend = 0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_1234;
  endfunction

  // Called at a negedge with stall/redirect already set: drive the memory,
  // check the protocol and the stream, then advance one clock.
  task automatic tick();
    if (mem_req) begin
      if (wait_cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = memf(mem_addr);
        wait_cnt  = 0;
        if (rnd_lat) lat = $urandom_range(0, 3);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
    end
    if (prev_pend) begin
      chk("req_held", {31'd0, mem_req}, 32'd1);
      chk("addr_held", mem_addr, prev_addr);
    end
    prev_pend = mem_req && !mem_ack;
    prev_addr = mem_addr;
    if (redirect) exp_pc = redirect_pc & ~32'd3;
    else if (insn_valid && !stall) begin
      chk("stream_pc", pc, exp_pc);
      chk("stream_insn", insn, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed_n++;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic model_reset();
    exp_pc = RESET_PC; wait_cnt = 0; prev_pend = 0; mem_ack = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, {31'd0, insn_valid}, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_insn"}, insn, 32'd0);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_addr"}, mem_addr, RESET_PC);
  endtask

  initial begin
    logic [31:0] first_new;
    int n;
    repeat (2) @(negedge clock);
    chk_reset_outs("rst");
    reset = 1'b0;
    #1 chk("idle_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("req_first", {31'd0, mem_req}, 32'd1);
    chk("req_addr", mem_addr, RESET_PC);

    // zero-wait stream
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zw_valid", {31'd0, insn_valid}, 32'd1);
      chk("zw_pc", pc, RESET_PC + 32'(4 * i));
    end

    // reset asserted between edges clears outputs at once
    #2 reset = 1'b1;
    #1 chk_reset_outs("midrst");
    model_reset();
    lat = 3;
    @(negedge clock);
    reset = 1'b0;
    tick();

    // wait states: address stable, nothing valid until the ack
    for (int i = 0; i < 4; i++) begin
      chk("ws_addr", mem_addr, RESET_PC);
      chk("ws_valid", {31'd0, insn_valid}, 32'd0);
      tick();
    end
    chk("ws_done_valid", {31'd0, insn_valid}, 32'd1);
    chk("ws_done_pc", pc, RESET_PC);

    // stall for 4 cycles while streaming
    lat = 0;
    stall = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("hold_req", {31'd0, mem_req}, 32'd0);
      chk("hold_pc", pc, RESET_PC);
      tick();
    end
    stall = 1'b0;
    chk("stall_end_pc", pc, RESET_PC);
    tick();
    chk("drain_pc", pc, RESET_PC + 32'd4);
    tick();
    chk("after_drain_pc", pc, RESET_PC + 32'd8);

    // redirect while a read is pending
    lat = 3;
    tick();
    redirect = 1'b1; redirect_pc = 32'h8002_0103;
    tick();
    redirect = 1'b0;
    chk("sq_addr", mem_addr, RESET_PC + 32'hC);
    chk("sq_valid", {31'd0, insn_valid}, 32'd0);
    first_new = '0; n = 0;
    while (!insn_valid && n < 20) begin
      if (mem_req && mem_addr != RESET_PC + 32'hC && first_new == '0) first_new = mem_addr;
      tick(); n++;
    end
    chk("rd_timeout", {31'd0, n < 20}, 32'd1);
    chk("rd_next_addr", first_new, 32'h8002_0100);
    chk("rd_pc", pc, 32'h8002_0100);
    chk("rd_insn", insn, memf(32'h8002_0100));

    // wrap at the top of the address space
    lat = 0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    n = 0;
    while (!insn_valid && n < 10) begin tick(); n++; end
    chk("wrap_timeout", {31'd0, n < 10}, 32'd1);
    chk("wrap_pc0", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_valid", {31'd0, insn_valid}, 32'd1);
    chk("wrap_pc1", pc, 32'h0000_0000);

    // random traffic against the stream model
    rnd_lat = 1;
    consumed_n = 0;
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
      tick();
    end
    stall = 1'b0; redirect = 1'b0;
    chk("progress", {31'd0, consumed_n > 100}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
